// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, decode offsets and widths
// used by the register-file completer and the wait-state counter.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ACCESS_WAIT = 2'd1,
      DONE        = 2'd2
   } apb_state_e;

   // Read-only word indices, relative to the first index past the RW bank
   localparam int ID_IDX_OFFSET  = 0;
   localparam int CNT_IDX_OFFSET = 1;

   localparam int APB_STRB_W = 4;
   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle between a requester (master) and a completer (slave).
interface apb_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_W-1:0]     PADDR;
   logic [DATA_W-1:0]     PWDATA;
   logic [APB_STRB_W-1:0] PSTRB;
   logic [DATA_W-1:0]     PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_wait_counter.sv
// Loadable down-counter for APB wait states; flags the last wait cycle
// (count == 1) and an empty count (count == 0).
module apb_wait_counter
   import apb_pkg::*;
#(
   parameter int CNT_W = WAIT_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             last_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == CNT_W'(1));
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_regfile_completer.sv
// APB completer with a byte-strobed RW register bank, a read-only ID word,
// a read-only count of successful transfers and programmable wait states.
module apb_regfile_completer
   import apb_pkg::*;
#(
   parameter int          ADDR_W      = 32,
   parameter int          DATA_W      = 32,
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
   input  logic  PCLK,
   input  logic  PRESETn,
   apb_if.slave  bus
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [IDX_W-1:0] RW_LIMIT = IDX_W'(NUM_REGS);
   localparam logic [IDX_W-1:0] ID_IDX   = IDX_W'(NUM_REGS + ID_IDX_OFFSET);
   localparam logic [IDX_W-1:0] CNT_IDX  = IDX_W'(NUM_REGS + CNT_IDX_OFFSET);

   apb_state_e state_q, state_d;

   logic [ADDR_W-1:0]     addr_q;
   logic                  write_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [APB_STRB_W-1:0] strb_q;
   logic [31:0]           xfer_cnt_q, xfer_cnt_d;
   logic [DATA_W-1:0]     prdata_q, prdata_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;

   logic                  setup, in_idle;
   logic                  cnt_load, cnt_dec, cnt_last, cnt_zero;
   logic [ADDR_W-1:0]     cur_addr;
   logic                  cur_write;
   logic [DATA_W-1:0]     cur_wdata;
   logic [APB_STRB_W-1:0] cur_strb;
   logic [IDX_W-1:0]      idx;
   logic                  is_rw, is_id, is_cnt, err;
   logic                  complete, commit, wr_commit;
   logic [DATA_W-1:0]     rdata;
   logic [DATA_W-1:0]     regs_rd [NUM_REGS];

   assign setup   = bus.PSEL && !bus.PENABLE;
   assign in_idle = (state_q == IDLE);

   // With zero wait states the transfer completes on the SETUP edge itself,
   // so decode must see the live bus rather than the latched copy.
   assign cur_addr  = in_idle ? bus.PADDR  : addr_q;
   assign cur_write = in_idle ? bus.PWRITE : write_q;
   assign cur_wdata = in_idle ? bus.PWDATA : wdata_q;
   assign cur_strb  = in_idle ? bus.PSTRB  : strb_q;

   assign idx    = cur_addr[ADDR_W-1:2];
   assign is_rw  = (idx < RW_LIMIT);
   assign is_id  = (idx == ID_IDX);
   assign is_cnt = (idx == CNT_IDX);
   assign err    = (cur_addr[1:0] != 2'b00) || !(is_rw || is_id || is_cnt)
                   || (cur_write && !is_rw);

   always_comb begin
      rdata = '0;
      if (is_rw) begin
         rdata = regs_rd[idx[SEL_W-1:0]];
      end else if (is_id) begin
         rdata = ID_VALUE;
      end else if (is_cnt) begin
         rdata = xfer_cnt_q;
      end
   end

   apb_wait_counter #(.CNT_W(WAIT_CNT_W)) u_wait_cnt (
      .clk_i      (PCLK),
      .rst_ni     (PRESETn),
      .load_i     (cnt_load),
      .load_val_i (WAIT_CNT_W'(WAIT_CYCLES)),
      .dec_i      (cnt_dec),
      .last_o     (cnt_last),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               cnt_load = 1'b1;
               state_d  = (WAIT_CYCLES == 0) ? DONE : ACCESS_WAIT;
            end
         end
         ACCESS_WAIT: begin
            if (!bus.PSEL) begin
               state_d = IDLE;
            end else if (bus.PENABLE) begin
               if (cnt_last || cnt_zero) begin
                  state_d = DONE;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Response, commit and counter update all happen on the edge entering DONE
   assign complete  = (state_d == DONE);
   assign commit    = complete && !err;
   assign wr_commit = commit && cur_write;

   always_comb begin
      pready_d   = complete;
      pslverr_d  = complete && err;
      prdata_d   = (commit && !cur_write) ? rdata : '0;
      xfer_cnt_d = commit ? (xfer_cnt_q + 32'd1) : xfer_cnt_q;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         strb_q     <= '0;
         xfer_cnt_q <= '0;
         prdata_q   <= '0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         xfer_cnt_q <= xfer_cnt_d;
         prdata_q   <= prdata_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
         if (in_idle && setup) begin
            addr_q  <= bus.PADDR;
            write_q <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
            strb_q  <= bus.PSTRB;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q, reg_d;

      always_comb begin
         reg_d = reg_q;
         if (wr_commit && (idx[SEL_W-1:0] == SEL_W'(gi))) begin
            for (int li = 0; li < APB_STRB_W; li++) begin
               if (cur_strb[li]) begin
                  reg_d[8*li +: 8] = cur_wdata[8*li +: 8];
               end
            end
         end
      end

      always_ff @(posedge PCLK or negedge PRESETn) begin
         if (!PRESETn) begin
            reg_q <= '0;
         end else begin
            reg_q <= reg_d;
         end
      end

      assign regs_rd[gi] = reg_q;
   end

   assign bus.PRDATA  = prdata_q;
   assign bus.PREADY  = pready_q;
   assign bus.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Directed bench: one completer with one wait state (table-driven vectors)
// and one with zero wait states (back-to-back transfers), plus reset/abort cases.
module tb_apb_regfile_completer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   apb_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
   apb_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

   apb_regfile_completer #(.WAIT_CYCLES(1)) dut1 (
      .PCLK    (clk),
      .PRESETn (rst_n),
      .bus     (bus1)
   );

   apb_regfile_completer #(.WAIT_CYCLES(0)) dut0 (
      .PCLK    (clk),
      .PRESETn (rst_n),
      .bus     (bus0)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   int errors = 0;
   int checks = 0;

   vec_t vecs [21];
   vec_t b2b  [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One complete transfer on the WAIT_CYCLES=1 completer; returns the ACCESS
   // cycle number in which PREADY was seen.
   task automatic xfer1(input vec_t v, input string tag, output logic [31:0] rd,
                        output logic er, output int cycles, output logic timeout);
      logic done;
      @(posedge clk); #1;
      bus1.PSEL    = 1'b1;
      bus1.PENABLE = 1'b0;
      bus1.PWRITE  = v.wr;
      bus1.PADDR   = v.addr;
      bus1.PWDATA  = v.wdata;
      bus1.PSTRB   = v.strb;
      @(posedge clk); #1;
      bus1.PENABLE = 1'b1;
      cycles = 0;
      done   = 1'b0;
      rd     = '0;
      er     = 1'b0;
      while (!done && cycles < 16) begin
         @(negedge clk);
         cycles++;
         if (bus1.PREADY) begin
            done = 1'b1;
            rd   = bus1.PRDATA;
            er   = bus1.PSLVERR;
         end else begin
            check({tag, "_wait_prdata"}, bus1.PRDATA, 32'h0);
            @(posedge clk); #1;
         end
      end
      timeout = !done;
      @(posedge clk); #1;
      bus1.PSEL    = 1'b0;
      bus1.PENABLE = 1'b0;
   endtask

   task automatic run1(input vec_t v, input string tag);
      logic [31:0] rd;
      logic        er, to;
      int          cyc;
      xfer1(v, tag, rd, er, cyc, to);
      $display("txn %s: wr=%0d addr=%h wdata=%h strb=%h -> prdata=%h pslverr=%0d access_cycle=%0d",
               tag, v.wr, v.addr, v.wdata, v.strb, rd, er, cyc);
      check({tag, "_timeout"}, 32'(to), 32'h0);
      check({tag, "_prdata"}, rd, v.exp_rdata);
      check({tag, "_pslverr"}, 32'(er), 32'(v.exp_err));
      check({tag, "_latency"}, 32'(cyc), 32'd2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic viol_ready;

      vecs[0]  = '{1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
      vecs[1]  = '{1'b0, 32'h04, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h00, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
      vecs[3]  = '{1'b0, 32'h24, 32'h0,         4'hF, 32'd3,         1'b0};
      vecs[4]  = '{1'b0, 32'h24, 32'h0,         4'hF, 32'd4,         1'b0};
      vecs[5]  = '{1'b1, 32'h00, 32'hFFFF_FFFF, 4'h5, 32'h0,         1'b0};
      vecs[6]  = '{1'b0, 32'h00, 32'h0,         4'hF, 32'h11FF_33FF, 1'b0};
      vecs[7]  = '{1'b0, 32'h20, 32'h0,         4'hF, 32'hA5B0_0001, 1'b0};
      vecs[8]  = '{1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
      vecs[9]  = '{1'b0, 32'h20, 32'h0,         4'hF, 32'hA5B0_0001, 1'b0};
      vecs[10] = '{1'b0, 32'h40, 32'h0,         4'hF, 32'h0,         1'b1};
      vecs[11] = '{1'b0, 32'h02, 32'h0,         4'hF, 32'h0,         1'b1};
      vecs[12] = '{1'b1, 32'h1C, 32'h1234_5678, 4'h0, 32'h0,         1'b0};
      vecs[13] = '{1'b0, 32'h1C, 32'h0,         4'hF, 32'h0,         1'b0};
      vecs[14] = '{1'b1, 32'h18, 32'hAABB_CCDD, 4'h8, 32'h0,         1'b0};
      vecs[15] = '{1'b0, 32'h18, 32'h0,         4'hF, 32'hAA00_0000, 1'b0};
      vecs[16] = '{1'b1, 32'h05, 32'h0102_0304, 4'hF, 32'h0,         1'b1};
      vecs[17] = '{1'b0, 32'h04, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
      vecs[18] = '{1'b0, 32'h28, 32'h0,         4'hF, 32'h0,         1'b1};
      vecs[19] = '{1'b1, 32'h24, 32'h0,         4'hF, 32'h0,         1'b1};
      vecs[20] = '{1'b0, 32'h24, 32'h0,         4'hF, 32'd14,        1'b0};

      b2b[0] = '{1'b1, 32'h00, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
      b2b[1] = '{1'b0, 32'h00, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0};
      b2b[2] = '{1'b0, 32'h20, 32'h0,         4'hF, 32'hA5B0_0001, 1'b0};
      b2b[3] = '{1'b0, 32'h24, 32'h0,         4'hF, 32'd3,         1'b0};
      b2b[4] = '{1'b0, 32'h24, 32'h0,         4'hF, 32'd4,         1'b0};

      bus1.PSEL = 1'b0; bus1.PENABLE = 1'b0; bus1.PWRITE = 1'b0;
      bus1.PADDR = '0;  bus1.PWDATA = '0;    bus1.PSTRB = '0;
      bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b0;
      bus0.PADDR = '0;  bus0.PWDATA = '0;    bus0.PSTRB = '0;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pready1",  32'(bus1.PREADY),  32'h0);
      check("rst_pslverr1", 32'(bus1.PSLVERR), 32'h0);
      check("rst_prdata1",  bus1.PRDATA,       32'h0);
      check("rst_pready0",  32'(bus0.PREADY),  32'h0);
      check("rst_prdata0",  bus0.PRDATA,       32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         run1(vecs[i], $sformatf("v%0d", i));
      end

      // Abort: SETUP then PSEL drops while waiting; the write must not land
      @(posedge clk); #1;
      bus1.PSEL = 1'b1; bus1.PENABLE = 1'b0; bus1.PWRITE = 1'b1;
      bus1.PADDR = 32'h08; bus1.PWDATA = 32'h5555_5555; bus1.PSTRB = 4'hF;
      @(posedge clk); #1;
      bus1.PSEL = 1'b0;
      viol_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         viol_ready = viol_ready | bus1.PREADY;
      end
      $display("txn abort: write 0x08 abandoned mid-wait, pready_seen=%0d", viol_ready);
      check("abort_pready", 32'(viol_ready), 32'h0);

      // PENABLE without a SETUP phase must be ignored
      @(posedge clk); #1;
      bus1.PSEL = 1'b1; bus1.PENABLE = 1'b1; bus1.PWRITE = 1'b1; bus1.PADDR = 32'h08;
      viol_ready = 1'b0;
      repeat (4) begin
         @(negedge clk);
         viol_ready = viol_ready | bus1.PREADY;
      end
      @(posedge clk); #1;
      bus1.PSEL = 1'b0; bus1.PENABLE = 1'b0;
      $display("txn violation: PENABLE without SETUP, pready_seen=%0d", viol_ready);
      check("noseq_pready", 32'(viol_ready), 32'h0);

      run1('{1'b0, 32'h08, 32'h0, 4'hF, 32'h0,   1'b0}, "post_abort_reg");
      run1('{1'b0, 32'h24, 32'h0, 4'hF, 32'd16,  1'b0}, "post_abort_cnt");

      // Zero wait states: back-to-back SETUP/ACCESS with no idle cycles
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         bus0.PSEL = 1'b1; bus0.PENABLE = 1'b0; bus0.PWRITE = b2b[i].wr;
         bus0.PADDR = b2b[i].addr; bus0.PWDATA = b2b[i].wdata; bus0.PSTRB = b2b[i].strb;
         @(negedge clk);
         if (i > 0) check($sformatf("b2b%0d_setup_pready", i), 32'(bus0.PREADY), 32'h0);
         @(posedge clk); #1;
         bus0.PENABLE = 1'b1;
         @(negedge clk);
         $display("txn b2b%0d: wr=%0d addr=%h -> pready=%0d prdata=%h pslverr=%0d",
                  i, b2b[i].wr, b2b[i].addr, bus0.PREADY, bus0.PRDATA, bus0.PSLVERR);
         check($sformatf("b2b%0d_pready", i),  32'(bus0.PREADY),  32'h1);
         check($sformatf("b2b%0d_prdata", i),  bus0.PRDATA,       b2b[i].exp_rdata);
         check($sformatf("b2b%0d_pslverr", i), 32'(bus0.PSLVERR), 32'(b2b[i].exp_err));
         @(posedge clk); #1;
      end
      bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0;

      // Reset mid-transfer: dut1 waiting on a write, dut0 showing a read response
      @(posedge clk); #1;
      bus1.PSEL = 1'b1; bus1.PENABLE = 1'b0; bus1.PWRITE = 1'b1;
      bus1.PADDR = 32'h0C; bus1.PWDATA = 32'h7777_7777; bus1.PSTRB = 4'hF;
      bus0.PSEL = 1'b1; bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b0; bus0.PADDR = 32'h20;
      @(posedge clk); #1;
      bus1.PENABLE = 1'b1;
      bus0.PENABLE = 1'b1;
      #1;
      check("prerst_pready0", 32'(bus0.PREADY), 32'h1);
      rst_n = 1'b0;
      #1;
      $display("txn reset: asserted mid-transfer, pready1=%0d pready0=%0d prdata0=%h",
               bus1.PREADY, bus0.PREADY, bus0.PRDATA);
      check("async_rst_pready0", 32'(bus0.PREADY), 32'h0);
      check("async_rst_prdata0", bus0.PRDATA,      32'h0);
      check("async_rst_pready1", 32'(bus1.PREADY), 32'h0);
      bus1.PSEL = 1'b0; bus1.PENABLE = 1'b0;
      bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run1('{1'b0, 32'h0C, 32'h0, 4'hF, 32'h0, 1'b0}, "post_rst_target");
      run1('{1'b0, 32'h04, 32'h0, 4'hF, 32'h0, 1'b0}, "post_rst_reg1");
      run1('{1'b0, 32'h24, 32'h0, 4'hF, 32'd2, 1'b0}, "post_rst_cnt");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
